// File: rtl/race_controller.sv
// ---------------------------------------------------------------------------
// race_controller
//
// Top-level sequencer for the two-car race. Generates the free-running 60 Hz
// game tick, runs the IDLE -> COUNTDOWN -> RACE <-> PAUSE -> FINISH flow,
// tracks checkpoint/lap progress for both cars from their map positions,
// keeps the race clock in whole seconds and decides the winner.
//
// Ports
//   clk        in   1   system clock
//   rst        in   1   synchronous, active-high reset
//   start_btn  in   1   debounced level, acts on rising edge
//   pause_btn  in   1   debounced level, acts on rising edge
//   p1_x/p1_y  in  10   car 1 map position
//   p2_x/p2_y  in  10   car 2 map position
//   state      out  3   0 IDLE, 2 COUNTDOWN, 3 PAUSE, 4 RACE, 5 FINISH
//   game_tick  out  1   one-cycle pulse at 60 Hz
//   countdown  out  2   countdown seconds remaining
//   lap1/lap2  out  3   completed laps per car
//   winner     out  2   0 none, 1 car 1, 2 car 2, 3 tie
//   race_sec   out 10   elapsed race seconds (saturates at 999)
// ---------------------------------------------------------------------------
module race_controller #(
    parameter int CLK_FREQ      = 100_000_000,
    parameter int COUNTDOWN_SEC = 3,
    parameter int LAPS          = 3,
    parameter int FIN_X0        = 0,
    parameter int FIN_X1        = 20,
    parameter int FIN_Y0        = 100,
    parameter int FIN_Y1        = 140,
    parameter int CP_X0         = 280,
    parameter int CP_X1         = 319,
    parameter int CP_Y0         = 100,
    parameter int CP_Y1         = 140
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start_btn,
    input  logic        pause_btn,
    input  logic [9:0]  p1_x,
    input  logic [9:0]  p1_y,
    input  logic [9:0]  p2_x,
    input  logic [9:0]  p2_y,
    output logic [2:0]  state,
    output logic        game_tick,
    output logic [1:0]  countdown,
    output logic [2:0]  lap1,
    output logic [2:0]  lap2,
    output logic [1:0]  winner,
    output logic [9:0]  race_sec
);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_COUNTDOWN = 3'd2,
        S_PAUSE     = 3'd3,
        S_RACE      = 3'd4,
        S_FINISH    = 3'd5
    } state_t;

    localparam logic [20:0] TICK_LIMIT = 21'(CLK_FREQ / 60);
    localparam logic [5:0]  SUB_LAST   = 6'd59;
    localparam logic [1:0]  CD_INIT    = 2'(COUNTDOWN_SEC);
    localparam logic [2:0]  LAPS_W     = 3'(LAPS);
    localparam logic [9:0]  SEC_MAX    = 10'd999;

    // Inclusive box test. Positions are widened to int so that a zero
    // lower bound does not turn into a trivially-true unsigned compare.
    function automatic logic in_box(
        input logic [9:0] x,
        input logic [9:0] y,
        input int         x0,
        input int         x1,
        input int         y0,
        input int         y1
    );
        int xi;
        int yi;
        xi = int'({22'd0, x});
        yi = int'({22'd0, y});
        return (xi >= x0) && (xi <= x1) && (yi >= y0) && (yi <= y1);
    endfunction

    // -----------------------------------------------------------------------
    // Game tick: counter runs 0..TICK_LIMIT, tick is high while it sits at
    // TICK_LIMIT, so the period is TICK_LIMIT+1 clocks. Free-runs always.
    // -----------------------------------------------------------------------
    logic [20:0] r_tick_cnt;
    logic        w_tick;

    assign w_tick    = (r_tick_cnt == TICK_LIMIT);
    assign game_tick = w_tick;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_tick_cnt <= 21'd0;
        end else if (w_tick) begin
            r_tick_cnt <= 21'd0;
        end else begin
            r_tick_cnt <= r_tick_cnt + 21'd1;
        end
    end

    // -----------------------------------------------------------------------
    // Button edge detection: a held button yields a single event.
    // -----------------------------------------------------------------------
    logic r_start_prev;
    logic r_pause_prev;
    logic w_start_rise;
    logic w_pause_rise;

    assign w_start_rise = start_btn & ~r_start_prev;
    assign w_pause_rise = pause_btn & ~r_pause_prev;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_start_prev <= 1'b0;
            r_pause_prev <= 1'b0;
        end else begin
            r_start_prev <= start_btn;
            r_pause_prev <= pause_btn;
        end
    end

    // -----------------------------------------------------------------------
    // FSM registers (declared early: the per-car logic keys off r_state).
    // -----------------------------------------------------------------------
    state_t      r_state;
    logic [1:0]  r_countdown;
    logic [1:0]  r_winner;
    logic [9:0]  r_race_sec;
    logic [5:0]  r_sub;

    logic        w_new_race;
    logic        w_racing;

    assign w_new_race = (r_state == S_IDLE) && w_start_rise;
    assign w_racing   = (r_state == S_RACE);

    // -----------------------------------------------------------------------
    // Per-car checkpoint / lap tracking. Only advances while racing, so
    // pause freezes the flags, the lap counts and the finish-zone history.
    // -----------------------------------------------------------------------
    logic [1:0]       w_lap_evt;
    logic [1:0]       w_final_lap;
    logic [1:0][2:0]  w_laps;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_car
            logic [9:0] w_x;
            logic [9:0] w_y;
            logic       w_in_cp;
            logic       w_in_fin;
            logic       w_evt;
            logic [2:0] r_lap;
            logic       r_cp_flag;
            logic       r_fin_prev;

            assign w_x = (gi == 0) ? p1_x : p2_x;
            assign w_y = (gi == 0) ? p1_y : p2_y;

            assign w_in_cp  = in_box(w_x, w_y, CP_X0, CP_X1, CP_Y0, CP_Y1);
            assign w_in_fin = in_box(w_x, w_y, FIN_X0, FIN_X1, FIN_Y0, FIN_Y1);

            // A lap needs a fresh entry into the finish box after having
            // visited the checkpoint since the previous lap.
            assign w_evt = w_racing && w_in_fin && !r_fin_prev && r_cp_flag
                           && (r_lap < LAPS_W);

            assign w_lap_evt[gi]   = w_evt;
            assign w_final_lap[gi] = w_evt && (r_lap == (LAPS_W - 3'd1));
            assign w_laps[gi]      = r_lap;

            always_ff @(posedge clk) begin
                if (rst) begin
                    r_lap      <= 3'd0;
                    r_cp_flag  <= 1'b0;
                    r_fin_prev <= 1'b0;
                end else if (w_new_race) begin
                    r_lap     <= 3'd0;
                    r_cp_flag <= 1'b0;
                end else if (w_racing) begin
                    r_fin_prev <= w_in_fin;
                    if (w_evt) begin
                        r_lap     <= r_lap + 3'd1;
                        r_cp_flag <= 1'b0;
                    end else if (w_in_cp) begin
                        r_cp_flag <= 1'b1;
                    end
                end
            end
        end
    endgenerate

    // -----------------------------------------------------------------------
    // Race FSM. The sub-second counter is shared between the countdown and
    // the race timer: it is cleared on countdown entry and is back at 0 on
    // the tick that enters RACE, so the first race second is a full one.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_countdown <= 2'd0;
            r_winner    <= 2'd0;
            r_race_sec  <= 10'd0;
            r_sub       <= 6'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_start_rise) begin
                        r_state     <= S_COUNTDOWN;
                        r_countdown <= CD_INIT;
                        r_winner    <= 2'd0;
                        r_race_sec  <= 10'd0;
                        r_sub       <= 6'd0;
                    end
                end

                S_COUNTDOWN: begin
                    if (w_tick) begin
                        if (r_sub == SUB_LAST) begin
                            r_sub <= 6'd0;
                            if (r_countdown <= 2'd1) begin
                                r_state     <= S_RACE;
                                r_countdown <= 2'd0;
                            end else begin
                                r_countdown <= r_countdown - 2'd1;
                            end
                        end else begin
                            r_sub <= r_sub + 6'd1;
                        end
                    end
                end

                S_RACE: begin
                    // Finishing beats a pause request in the same cycle.
                    if (|w_final_lap) begin
                        r_state  <= S_FINISH;
                        r_winner <= w_final_lap;
                    end else if (w_pause_rise) begin
                        r_state <= S_PAUSE;
                    end

                    if (w_tick) begin
                        if (r_sub == SUB_LAST) begin
                            r_sub <= 6'd0;
                            if (r_race_sec != SEC_MAX) begin
                                r_race_sec <= r_race_sec + 10'd1;
                            end
                        end else begin
                            r_sub <= r_sub + 6'd1;
                        end
                    end
                end

                S_PAUSE: begin
                    if (w_pause_rise) begin
                        r_state <= S_RACE;
                    end
                end

                S_FINISH: begin
                    if (w_start_rise) begin
                        r_state <= S_IDLE;
                    end
                end

                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign state     = r_state;
    assign countdown = r_countdown;
    assign winner    = r_winner;
    assign race_sec  = r_race_sec;
    assign lap1      = w_laps[0];
    assign lap2      = w_laps[1];

endmodule

// File: tb/tb_race_controller.sv
// ---------------------------------------------------------------------------
// tb_race_controller
//
// Directed bench for race_controller with CLK_FREQ=600 (tick every 11 clk).
// Lap behaviour in RACE is driven from a table of position/button records
// with hand-computed expectations; reset, countdown, pause, win, tie and
// abort are hand-written sequences.
// ---------------------------------------------------------------------------
module tb_race_controller;

    logic       clk = 1'b0;
    logic       rst;
    logic       start_btn;
    logic       pause_btn;
    logic [9:0] p1_x, p1_y, p2_x, p2_y;
    logic [2:0] state;
    logic       game_tick;
    logic [1:0] countdown;
    logic [2:0] lap1, lap2;
    logic [1:0] winner;
    logic [9:0] race_sec;

    race_controller #(
        .CLK_FREQ(600)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start_btn (start_btn),
        .pause_btn (pause_btn),
        .p1_x      (p1_x),
        .p1_y      (p1_y),
        .p2_x      (p2_x),
        .p2_y      (p2_y),
        .state     (state),
        .game_tick (game_tick),
        .countdown (countdown),
        .lap1      (lap1),
        .lap2      (lap2),
        .winner    (winner),
        .race_sec  (race_sec)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int tick_seen = 0;

    typedef struct {
        logic start;
        logic pause;
        int   p1x, p1y, p2x, p2y;
        int   cycles;
        int   st, l1, l2, win;
    } vec_t;

    localparam int NV = 16;
    vec_t tab[NV];

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // One clock; a tick visible now is consumed by the DUT at this edge.
    task automatic step();
        if (game_tick) tick_seen++;
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ticks(input int target, input string name);
        int guard;
        guard = 0;
        while (tick_seen < target && guard < 20000) begin
            step();
            guard++;
        end
        check({name, "_tick_timeout"}, int'(tick_seen >= target), 1);
    endtask

    task automatic wait_sec(input int target, input int max_cyc, input string name);
        int guard;
        guard = 0;
        while (int'(race_sec) != target && guard < max_cyc) begin
            step();
            guard++;
        end
        check(name, int'(race_sec), target);
    endtask

    task automatic set_pos(input int x1, input int y1, input int x2, input int y2);
        p1_x = 10'(x1);
        p1_y = 10'(y1);
        p2_x = 10'(x2);
        p2_y = 10'(y2);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int exp_st;
        int exp_win;

        //            st  pa  p1x  p1y  p2x  p2y  cyc  st l1 l2 w
        tab[0]  = '{1'b0, 1'b0,  10, 120, 150,  50,   3, 4, 0, 0, 0}; // finish, no cp
        tab[1]  = '{1'b0, 1'b0, 150,  50, 150,  50,   3, 4, 0, 0, 0};
        tab[2]  = '{1'b0, 1'b0,  10, 120, 150,  50,   3, 4, 0, 0, 0}; // re-enter, no cp
        tab[3]  = '{1'b0, 1'b0, 300, 120, 150,  50,   3, 4, 0, 0, 0}; // checkpoint
        tab[4]  = '{1'b0, 1'b0,  10, 120, 150,  50,   3, 4, 1, 0, 0}; // lap 1
        tab[5]  = '{1'b0, 1'b0,  10, 120, 150,  50, 100, 4, 1, 0, 0}; // sit on finish
        tab[6]  = '{1'b1, 1'b0, 280, 100, 150,  50,   3, 4, 1, 0, 0}; // cp corner, start ignored
        tab[7]  = '{1'b0, 1'b0,  21, 120, 150,  50,   3, 4, 1, 0, 0}; // just right of finish
        tab[8]  = '{1'b0, 1'b0,  20, 141, 150,  50,   3, 4, 1, 0, 0}; // just below finish
        tab[9]  = '{1'b0, 1'b0,  20, 140, 150,  50,   3, 4, 2, 0, 0}; // finish corner: lap 2
        tab[10] = '{1'b0, 1'b0, 150,  50, 279, 120,   3, 4, 2, 0, 0}; // car2 just left of cp
        tab[11] = '{1'b0, 1'b0, 150,  50,   0, 100,   3, 4, 2, 0, 0}; // car2 finish, no cp
        tab[12] = '{1'b0, 1'b0, 150,  50, 319, 140,   3, 4, 2, 0, 0}; // car2 cp corner
        tab[13] = '{1'b0, 1'b0, 150,  50, 150,  50,   3, 4, 2, 0, 0};
        tab[14] = '{1'b0, 1'b0, 150,  50,   0, 100,   3, 4, 2, 1, 0}; // car2 lap 1
        tab[15] = '{1'b0, 1'b0, 150,  50, 150,  50,   3, 4, 2, 1, 0};

        // ---------------- reset ----------------
        rst = 1'b1;
        start_btn = 1'b0;
        pause_btn = 1'b0;
        set_pos(150, 50, 150, 50);
        repeat (3) step();
        check("rst_state", int'(state), 0);
        check("rst_tick", int'(game_tick), 0);
        check("rst_countdown", int'(countdown), 0);
        check("rst_lap1", int'(lap1), 0);
        check("rst_lap2", int'(lap2), 0);
        check("rst_winner", int'(winner), 0);
        check("rst_race_sec", int'(race_sec), 0);
        rst = 1'b0;
        repeat (9) step();
        check("tick_before_first", int'(game_tick), 0);
        step();
        check("tick_first", int'(game_tick), 1);
        step();
        check("tick_after_first", int'(game_tick), 0);
        repeat (10) step();
        check("tick_second", int'(game_tick), 1);
        $display("reset/tick sequence done: state=%0d", state);

        // ---------------- start + countdown ----------------
        start_btn = 1'b1;
        step();
        check("start_state", int'(state), 2);
        check("start_countdown", int'(countdown), 3);
        tick_seen = 0;
        repeat (49) step();
        check("held_start_state", int'(state), 2);
        check("held_start_countdown", int'(countdown), 3);
        start_btn = 1'b0;
        wait_ticks(59, "cd59");
        check("cd_tick59", int'(countdown), 3);
        wait_ticks(60, "cd60");
        check("cd_tick60", int'(countdown), 2);
        wait_ticks(120, "cd120");
        check("cd_tick120", int'(countdown), 1);
        wait_ticks(179, "cd179");
        check("cd_tick179_state", int'(state), 2);
        wait_ticks(180, "cd180");
        check("race_state", int'(state), 4);
        check("race_countdown", int'(countdown), 0);
        $display("countdown done: state=%0d countdown=%0d", state, countdown);

        // ---------------- lap table ----------------
        for (int i = 0; i < NV; i++) begin
            start_btn = tab[i].start;
            pause_btn = tab[i].pause;
            set_pos(tab[i].p1x, tab[i].p1y, tab[i].p2x, tab[i].p2y);
            repeat (tab[i].cycles) step();
            $display("vec %0d: p1=(%0d,%0d) p2=(%0d,%0d) state=%0d lap1=%0d lap2=%0d winner=%0d",
                     i, tab[i].p1x, tab[i].p1y, tab[i].p2x, tab[i].p2y, state, lap1, lap2, winner);
            check($sformatf("vec%0d_state", i), int'(state), tab[i].st);
            check($sformatf("vec%0d_lap1", i), int'(lap1), tab[i].l1);
            check($sformatf("vec%0d_lap2", i), int'(lap2), tab[i].l2);
            check($sformatf("vec%0d_winner", i), int'(winner), tab[i].win);
        end
        check("table_race_sec", int'(race_sec), 0);

        // ---------------- pause / resume ----------------
        wait_sec(2, 3000, "reach_sec2");
        pause_btn = 1'b1;
        step();
        check("pause_state", int'(state), 3);
        tick_seen = 0;
        set_pos(300, 120, 150, 50);      // visit checkpoint while paused
        wait_ticks(100, "pause100");
        set_pos(150, 50, 150, 50);
        wait_ticks(200, "pause200");
        check("pause_held_state", int'(state), 3);
        check("pause_race_sec", int'(race_sec), 2);
        check("pause_lap1", int'(lap1), 2);
        check("pause_lap2", int'(lap2), 1);
        pause_btn = 1'b0;
        step();
        pause_btn = 1'b1;
        step();
        check("resume_state", int'(state), 4);
        pause_btn = 1'b0;
        set_pos(10, 120, 150, 50);       // checkpoint seen in pause must not count
        repeat (3) step();
        check("resume_no_lap", int'(lap1), 2);
        wait_sec(3, 800, "resume_sec3");
        $display("pause sequence done: state=%0d race_sec=%0d", state, race_sec);

        // ---------------- car 1 wins ----------------
        set_pos(150, 50, 150, 50);  repeat (2) step();
        set_pos(300, 120, 150, 50); repeat (2) step();
        set_pos(150, 50, 150, 50);  repeat (2) step();
        set_pos(10, 120, 150, 50);  step();
        check("win_lap1", int'(lap1), 3);
        check("win_winner", int'(winner), 1);
        check("win_state", int'(state), 5);
        set_pos(150, 50, 150, 50);  repeat (2) step();
        set_pos(300, 120, 300, 120); repeat (2) step();
        set_pos(150, 50, 150, 50);  repeat (2) step();
        set_pos(10, 120, 10, 120);  repeat (2) step();
        check("post_win_lap1", int'(lap1), 3);
        check("post_win_lap2", int'(lap2), 1);
        check("post_win_winner", int'(winner), 1);
        repeat (700) step();
        check("finish_frozen_sec", int'(race_sec), 3);
        check("finish_frozen_state", int'(state), 5);
        $display("win sequence done: winner=%0d lap1=%0d", winner, lap1);

        // ---------------- FINISH -> IDLE -> new race ----------------
        set_pos(150, 50, 150, 50);
        start_btn = 1'b1;
        step();
        check("finish_to_idle", int'(state), 0);
        repeat (3) step();
        check("idle_held_start", int'(state), 0);
        check("idle_keeps_lap1", int'(lap1), 3);
        check("idle_keeps_winner", int'(winner), 1);
        start_btn = 1'b0;
        step();
        start_btn = 1'b1;
        step();
        check("restart_state", int'(state), 2);
        check("restart_lap1", int'(lap1), 0);
        check("restart_lap2", int'(lap2), 0);
        check("restart_winner", int'(winner), 0);
        check("restart_race_sec", int'(race_sec), 0);
        tick_seen = 0;
        start_btn = 1'b0;
        wait_ticks(180, "cd2_180");
        check("race2_state", int'(state), 4);

        // ---------------- tie, finish beats pause ----------------
        for (int lap = 1; lap <= 3; lap++) begin
            set_pos(300, 120, 290, 110); repeat (2) step();
            set_pos(150, 50, 150, 50);   repeat (2) step();
            set_pos(10, 120, 5, 110);
            if (lap == 3) pause_btn = 1'b1;
            step();
            exp_st  = (lap == 3) ? 5 : 4;
            exp_win = (lap == 3) ? 3 : 0;
            $display("tie lap %0d: state=%0d lap1=%0d lap2=%0d winner=%0d",
                     lap, state, lap1, lap2, winner);
            check($sformatf("tie%0d_lap1", lap), int'(lap1), lap);
            check($sformatf("tie%0d_lap2", lap), int'(lap2), lap);
            check($sformatf("tie%0d_state", lap), int'(state), exp_st);
            check($sformatf("tie%0d_winner", lap), int'(winner), exp_win);
            pause_btn = 1'b0;
            set_pos(150, 50, 150, 50);   repeat (2) step();
        end

        // ---------------- abort during countdown ----------------
        start_btn = 1'b1;
        step();
        check("abort_idle", int'(state), 0);
        start_btn = 1'b0;
        step();
        start_btn = 1'b1;
        step();
        check("abort_cd_state", int'(state), 2);
        tick_seen = 0;
        start_btn = 1'b0;
        wait_ticks(60, "abort60");
        check("abort_cd2", int'(countdown), 2);
        rst = 1'b1;
        step();
        check("abort_state", int'(state), 0);
        check("abort_countdown", int'(countdown), 0);
        rst = 1'b0;
        step();
        check("abort_stays_idle", int'(state), 0);
        $display("abort sequence done: state=%0d", state);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/race_controller.md
Name: race_controller

Overview:
- Top-level race sequencer for the two-car game.
- Owns the 60 Hz game tick and drives the 3-bit `state` bus consumed by both PhysicsEngine instances. Physics advances only while `state` is 4 (RACE).
- Runs the pre-race countdown, pause/resume, per-car checkpoint/lap tracking from car positions, race timer and winner decision.

Parameters:
- CLK_FREQ, 100_000_000, system clock in Hz; TICK_LIMIT = CLK_FREQ/60.
- COUNTDOWN_SEC, 3, countdown seconds (1..3).
- LAPS, 3, laps to win (1..7).
- FIN_X0, FIN_X1, FIN_Y0, FIN_Y1, 0/20/100/140, finish-line box, inclusive bounds, map pixels.
- CP_X0, CP_X1, CP_Y0, CP_Y1, 280/319/100/140, checkpoint box, inclusive bounds.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- start_btn  in  1  debounced level; acts on rising edge.
- pause_btn  in  1  debounced level; acts on rising edge.
- p1_x, p1_y  in  10 each  car 1 position (pos_x/pos_y of PhysicsEngine 1).
- p2_x, p2_y  in  10 each  car 2 position.
- state  out  3  0 IDLE, 2 COUNTDOWN, 3 PAUSE, 4 RACE, 5 FINISH; 1, 6, 7 unused.
- game_tick  out  1  one-cycle pulse at 60 Hz.
- countdown  out  2  seconds remaining, for display.
- lap1, lap2  out  3 each  completed laps.
- winner  out  2  0 none, 1 car 1, 2 car 2, 3 tie.
- race_sec  out  10  elapsed race seconds.

Behaviour:
- Reset: state=0, game_tick=0, countdown=0, lap1=lap2=0, winner=0, race_sec=0. Tick counter, sub-second counter, checkpoint flags, zone-history regs and button-history regs are all cleared. Reset mid-race aborts immediately.
- Tick generation:
  - 21-bit counter counts 0..TICK_LIMIT.
  - game_tick=1 in the cycle the counter equals TICK_LIMIT; the counter returns to 0 on the next clock.
  - Period is TICK_LIMIT+1 cycles. The tick free-runs in every state.
- Button edges: each button is registered; rise = current & ~previous. A held button produces one event only.
- FSM (all transitions registered, one cycle after the event):
  - IDLE: start rise → COUNTDOWN. Load countdown=COUNTDOWN_SEC; clear laps, winner, race_sec, sub-second counter and checkpoint flags.
  - COUNTDOWN: a 6-bit sub-counter counts game_ticks 0..59. On the 60th tick, countdown decrements. When countdown would go 1→0, enter RACE with countdown=0. pause and start are ignored.
  - RACE: pause rise → PAUSE. A lap reaching LAPS → FINISH. start is ignored.
  - PAUSE: pause rise → RACE. Timer frozen, lap logic frozen, zone history held.
  - FINISH: laps, winner and race_sec are frozen. start rise → IDLE; outputs keep their values until the next COUNTDOWN entry clears them.
- Race timer: in RACE only, counts game_ticks 0..59. On the 60th tick race_sec increments, saturating at 999.
- Lap logic (per car, evaluated every clk while in RACE):
  - in_cp / in_fin are combinational inclusive box tests.
  - cp_flag sets when in_cp=1.
  - A lap counts on the rising edge of in_fin (registered in_fin_prev) only if cp_flag=1. On a count, lap increments and cp_flag clears.
  - A finish entry without a checkpoint visit is ignored. Laps never exceed LAPS.
- Winner: evaluated in the cycle the lap increments.
  - Only car 1 hits LAPS → winner=1. Only car 2 → winner=2. Both in the same cycle → winner=3.
  - State becomes 5 on the next clock.
- Simultaneous events in RACE: finish takes priority over pause.

Test Plan (CLK_FREQ=600, so TICK_LIMIT=10, tick every 11 clk):
- Reset: pulse rst → state=0, laps=0, winner=0, race_sec=0. game_tick first asserts 10 cycles after rst deasserts, then every 11 cycles.
- Start and countdown: start_btn rises and is held for 50 cycles → state=2 with countdown=3; countdown=2 after 60 ticks, 1 after 120 ticks; state=4 with countdown=0 after 180 ticks; exactly one start event.
- Laps: car 1 goes finish(10,120) → out → finish, lap1=0. Then cp(300,120) → finish: lap1=1. Sitting inside finish for 100 cycles: lap1 stays 1.
- Win and tie: with LAPS=3, car 1 completes its 3rd lap → winner=1, state=5 next clk, further laps ignored. Rerun with both cars entering finish in the same cycle on lap 3 → winner=3.
- Pause: at race_sec=2, a pause rise gives state=3; 200 ticks later race_sec is still 2 and laps are unchanged; a second pause rise gives state=4 and counting resumes.
- Abort and restart: rst during countdown=2 → state=0 next clk. start rise in FINISH → state=0; the next start clears laps and winner.
